// File: rtl/arbiter_n_if.sv
// arbiter_n_if: request/grant bundle between requesters and arbiter_n
//   req       : per-requester level request
//   arb_type  : scheme select (0 fixed-low, 1 fixed-selectable, 2 round robin, 3 random, 4..7 none)
//   prio_sel  : top-priority index for scheme 1
//   hold_en   : enables grant holding
//   gnt       : registered one-hot-or-zero grant
//   gnt_id    : index of the granted requester, 0 when idle
//   gnt_valid : |gnt
interface arbiter_n_if #(
    parameter int N = 4
) ();
    localparam int W = $clog2(N);
    logic [N-1:0] req;
    logic [2:0]   arb_type;
    logic [W-1:0] prio_sel;
    logic         hold_en;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_id;
    logic         gnt_valid;
    modport master (output req, arb_type, prio_sel, hold_en, input gnt, gnt_id, gnt_valid);
    modport slave  (input req, arb_type, prio_sel, hold_en, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/arbiter_n.sv
// arbiter_n: N-way arbiter with fixed, selectable, round-robin and LFSR-random schemes plus bounded grant holding
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : arbiter_n_if slave (req/arb_type/prio_sel/hold_en in, gnt/gnt_id/gnt_valid out)
module arbiter_n #(
    parameter int         N         = 4,
    parameter int         MAX_HOLD  = 4,
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    arbiter_n_if.slave bus
);
    localparam int W = $clog2(N);
    logic [7:0]   r_lfsr;
    logic [7:0]   r_hold_cnt;
    logic [W-1:0] r_rr_ptr;
    logic [W-1:0] r_gnt_id;
    logic [N-1:0] r_gnt;
    logic [W-1:0] w_low;
    logic [W-1:0] w_rr;
    logic [W-1:0] w_top;
    logic [W-1:0] w_sel;
    logic         w_pref;
    logic         w_scheme_on;
    logic         w_hold;
    logic         w_new;
    logic         w_fb;
    // Reverse scans so the last hit is the lowest index / first index from rr_ptr
    always_comb begin
        w_low = '0;
        w_rr  = '0;
        for (int i = N - 1; i >= 0; i--) if (bus.req[i]) w_low = W'(i);
        for (int i = N - 1; i >= 0; i--) if (bus.req[(int'(r_rr_ptr) + i) % N]) w_rr = W'((int'(r_rr_ptr) + i) % N);
    end
    // Random scheme reuses the selectable-priority rule with an LFSR-derived top index
    assign w_top       = (bus.arb_type == 3'd3) ? ((int'(r_lfsr[W-1:0]) < N) ? r_lfsr[W-1:0] : '0) : bus.prio_sel;
    assign w_pref      = (int'(w_top) < N) && bus.req[w_top];
    assign w_sel       = (bus.arb_type == 3'd2) ? w_rr : (bus.arb_type == 3'd0 || !w_pref) ? w_low : w_top;
    assign w_scheme_on = bus.arb_type < 3'd4;
    assign w_hold      = w_scheme_on && bus.hold_en && (|r_gnt) && bus.req[r_gnt_id] && (int'(r_hold_cnt) < MAX_HOLD);
    assign w_new       = w_scheme_on && (|bus.req) && !w_hold;
    assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr     <= LFSR_SEED;
            r_hold_cnt <= '0;
            r_rr_ptr   <= '0;
            r_gnt_id   <= '0;
            r_gnt      <= '0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            if (w_hold) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end else if (w_new) begin
                r_gnt      <= N'(1) << w_sel;
                r_gnt_id   <= w_sel;
                r_hold_cnt <= 8'd1;
                r_rr_ptr   <= (int'(w_sel) == N - 1) ? '0 : w_sel + 1'b1;
            end else begin
                r_gnt      <= '0;
                r_gnt_id   <= '0;
                r_hold_cnt <= '0;
            end
        end
    end
    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = |r_gnt;
endmodule
